bcd_addsub_serial: RTL

//  Parametrised digit-serial BCD adder/subtractor with valid/ready handshakes.

---
 rtl/bcd_addsub_serial.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/bcd_addsub_serial.sv
// Digit-serial BCD adder/subtractor, DPC digits per cycle, valid/ready on both sides.
// Subtraction adds the nine's complement of B with an inverted carry-in (ten's complement).
module bcd_addsub_serial #(
  parameter int N_DIGITS = 3,
  parameter int DPC      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mode,
  input  logic                  cin,
  input  logic [4*N_DIGITS-1:0] A,
  input  logic [4*N_DIGITS-1:0] B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*N_DIGITS-1:0] Sum,
  output logic                  Cout,
  output logic                  invalid
);

  localparam int W     = 4 * N_DIGITS;
  localparam int STEPS = N_DIGITS / DPC;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sh_q, sh_d, sum_q, sum_d;
  logic            cout_q, cout_d, inv_q, inv_d, bad_q, bad_d, carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [W-1:0]    digs, sh_next;
  logic [4:0]      s;
  logic [3:0]      d;
  logic            c;

  function automatic logic any_gt9(input logic [W-1:0] v);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < N_DIGITS; i++) r = r | (v[4*i +: 4] > 4'd9);
    return r;
  endfunction

  function automatic logic [W-1:0] nines(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) r[4*i +: 4] = 4'd9 - v[4*i +: 4];
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      inv_q   <= 1'b0;
      bad_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      inv_q   <= inv_d;
      bad_q   <= bad_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    inv_d   = inv_q;
    bad_d   = bad_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    digs    = '0;
    s       = '0;
    d       = '0;
    c       = carry_q;

    // DPC-digit ripple slice over the low digits of the shifting operand registers
    for (int unsigned j = 0; j < DPC; j++) begin
      s = {1'b0, a_q[4*j +: 4]} + {1'b0, b_q[4*j +: 4]} + {4'd0, c};
      if (s > 5'd9) begin
        d = s[3:0] + 4'd6;
        c = 1'b1;
      end else begin
        d = s[3:0];
        c = 1'b0;
      end
      digs[4*j +: 4] = d;
    end
    sh_next = (sh_q >> (4*DPC)) | (digs << (W - 4*DPC));

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = mode ? nines(B) : B;
          carry_d = mode ? ~cin : cin;
          bad_d   = any_gt9(A) | any_gt9(B);
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // Digit check is flagged at capture and resolved here, giving invalid ops a one-cycle latency.
        if (bad_q) begin
          sum_d   = '0;
          cout_d  = 1'b0;
          inv_d   = 1'b1;
          state_d = DONE;
        end else begin
          a_d     = a_q >> (4*DPC);
          b_d     = b_q >> (4*DPC);
          carry_d = c;
          sh_d    = sh_next;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CW'(STEPS - 1)) begin
            sum_d   = sh_next;
            cout_d  = c;
            inv_d   = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign invalid   = inv_q;

endmodule
